hazard_control_unit: RTL and testbench

- Consumes the decode-to-execute pipeline register outputs (rd, rs1, rs2, memoryReadEnable, registerWriteEnable, pcUpdate) together with the decode-stage, memory-stage and writeback-stage register indices.
- Drives the stall, flush and forwarding controls back into the pipeline registers and the execute-stage ALU muxes.
- Contains a small FSM for data-memory wait stalls with a timeout, and saturating stall/flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 37 +++
 rtl/forwarding_unit.sv | 21 ++
 rtl/hazard_control_unit.sv | 184 ++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard control slice: forwarding
// select encodings, memory-wait FSM states and the forwarding helper.
package pipeline_ctrl_pkg;

    // ALU operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Data-memory wait tracker states
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // Picks the freshest producer of a source register; the memory stage holds
    // the younger result, so it wins over writeback. x0 is hardwired zero and
    // is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_mem,
        input logic       wr_mem,
        input logic [4:0] rd_wb,
        input logic       wr_wb
    );
        logic [1:0] sel;
        if (wr_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
            sel = FWD_MEM;
        end else if (wr_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational ALU operand forwarding selects for the execute stage.
module forwarding_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs1Ex,
    input  logic [4:0] rs2Ex,
    input  logic [4:0] rdMem,
    input  logic       regWriteMem,
    input  logic [4:0] rdWb,
    input  logic       regWriteWb,
    output logic [1:0] forwardA,
    output logic [1:0] forwardB
);

    // Resolve each operand independently against the MEM and WB producers
    always_comb begin
        forwardA = fwd_select(rs1Ex, rdMem, regWriteMem, rdWb, regWriteWb);
        forwardB = fwd_select(rs2Ex, rdMem, regWriteMem, rdWb, regWriteWb);
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: stall/flush generation, operand forwarding,
// data-memory wait tracking with timeout, and stall/flush perf counters.
module hazard_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int STALL_CNT_W = 32,
    parameter int FLUSH_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             rs1Id,
    input  logic [4:0]             rs2Id,
    input  logic                   useRs1Id,
    input  logic                   useRs2Id,
    input  logic [4:0]             rs1Ex,
    input  logic [4:0]             rs2Ex,
    input  logic [4:0]             rdEx,
    input  logic                   memReadEx,
    input  logic                   branchTakenEx,
    input  logic [4:0]             rdMem,
    input  logic                   regWriteMem,
    input  logic                   memReqMem,
    input  logic                   memBusy,
    input  logic [4:0]             rdWb,
    input  logic                   regWriteWb,
    output logic                   pcStall,
    output logic                   ifIdStall,
    output logic                   ifIdFlush,
    output logic                   idExStall,
    output logic                   idExFlush,
    output logic                   exMemStall,
    output logic                   memWbFlush,
    output logic [1:0]             forwardA,
    output logic [1:0]             forwardB,
    output logic                   memTimeout,
    output logic [STALL_CNT_W-1:0] stallCycles,
    output logic [FLUSH_CNT_W-1:0] flushCount
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_MAX = {FLUSH_CNT_W{1'b1}};

    logic              mem_stall_s;
    logic              load_use_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;
    mem_state_e        state_r;
    mem_state_e        state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_next_s;
    logic              mem_timeout_r;
    logic              mem_timeout_next_s;
    logic [STALL_CNT_W-1:0] stall_cycles_r;
    logic [FLUSH_CNT_W-1:0] flush_count_r;

    forwarding_unit u_forwarding_unit (
        .rs1Ex       (rs1Ex),
        .rs2Ex       (rs2Ex),
        .rdMem       (rdMem),
        .regWriteMem (regWriteMem),
        .rdWb        (rdWb),
        .regWriteWb  (regWriteWb),
        .forwardA    (fwd_a_s),
        .forwardB    (fwd_b_s)
    );

    // Raw hazard terms; x0 as a load destination never creates a dependency
    always_comb begin
        mem_stall_s = memReqMem && memBusy;
        load_use_s  = memReadEx && (rdEx != 5'd0) &&
                      ((useRs1Id && (rdEx == rs1Id)) || (useRs2Id && (rdEx == rs2Id)));
    end

    // Prioritised stall/flush controls: memory wait freezes everything (a taken
    // branch stays in EX and flushes once memory is ready), then branch, then load-use
    always_comb begin
        pcStall    = 1'b0;
        ifIdStall  = 1'b0;
        ifIdFlush  = 1'b0;
        idExStall  = 1'b0;
        idExFlush  = 1'b0;
        exMemStall = 1'b0;
        memWbFlush = 1'b0;
        forwardA   = FWD_REG;
        forwardB   = FWD_REG;
        if (reset) begin
            pcStall = 1'b0;
        end else begin
            forwardA = fwd_a_s;
            forwardB = fwd_b_s;
            if (mem_stall_s) begin
                pcStall    = 1'b1;
                ifIdStall  = 1'b1;
                idExStall  = 1'b1;
                exMemStall = 1'b1;
                memWbFlush = 1'b1;
            end else if (branchTakenEx) begin
                ifIdFlush = 1'b1;
                idExFlush = 1'b1;
            end else if (load_use_s) begin
                pcStall   = 1'b1;
                ifIdStall = 1'b1;
                idExFlush = 1'b1;
            end else begin
                pcStall = 1'b0;
            end
        end
    end

    // Memory-wait tracker next state: counts consecutive wait cycles and
    // latches a sticky timeout once the limit is reached with memory still busy
    always_comb begin
        state_next_s       = state_r;
        wait_cnt_next_s    = wait_cnt_r;
        mem_timeout_next_s = mem_timeout_r;
        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    state_next_s    = MEM_WAIT;
                    wait_cnt_next_s = WAIT_W'(1);
                end else begin
                    wait_cnt_next_s = {WAIT_W{1'b0}};
                end
            end
            MEM_WAIT: begin
                if (mem_stall_s) begin
                    if (wait_cnt_r != WAIT_MAX) begin
                        wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
                    end else begin
                        wait_cnt_next_s = wait_cnt_r;
                    end
                    if ((wait_cnt_r == WAIT_MAX) && memBusy) begin
                        mem_timeout_next_s = 1'b1;
                    end else begin
                        mem_timeout_next_s = mem_timeout_r;
                    end
                end else begin
                    state_next_s    = RUN;
                    wait_cnt_next_s = {WAIT_W{1'b0}};
                end
            end
            default: begin
                state_next_s    = RUN;
                wait_cnt_next_s = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Memory-wait tracker state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= RUN;
            wait_cnt_r    <= {WAIT_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            wait_cnt_r    <= wait_cnt_next_s;
            mem_timeout_r <= mem_timeout_next_s;
        end
    end

    // Saturating performance counters for stalled cycles and branch flushes
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_r <= {STALL_CNT_W{1'b0}};
            flush_count_r  <= {FLUSH_CNT_W{1'b0}};
        end else begin
            if (pcStall && (stall_cycles_r != STALL_MAX)) begin
                stall_cycles_r <= stall_cycles_r + STALL_CNT_W'(1);
            end
            if (branchTakenEx && !mem_stall_s && (flush_count_r != FLUSH_MAX)) begin
                flush_count_r <= flush_count_r + FLUSH_CNT_W'(1);
            end
        end
    end

    assign memTimeout  = mem_timeout_r;
    assign stallCycles = stall_cycles_r;
    assign flushCount  = flush_count_r;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit.
module tb_hazard_control_unit;
    import pipeline_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic [4:0]  rs1Id, rs2Id, rs1Ex, rs2Ex, rdEx, rdMem, rdWb;
    logic        useRs1Id, useRs2Id, memReadEx, branchTakenEx;
    logic        regWriteMem, memReqMem, memBusy, regWriteWb;
    logic        pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush;
    logic        exMemStall, memWbFlush, memTimeout;
    logic [1:0]  forwardA, forwardB;
    logic [31:0] stallCycles;
    logic [1:0]  flushCount;

    int tests = 0;
    int fails = 0;

    hazard_control_unit #(
        .MEM_TIMEOUT (4),
        .STALL_CNT_W (32),
        .FLUSH_CNT_W (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rs1Id         (rs1Id),
        .rs2Id         (rs2Id),
        .useRs1Id      (useRs1Id),
        .useRs2Id      (useRs2Id),
        .rs1Ex         (rs1Ex),
        .rs2Ex         (rs2Ex),
        .rdEx          (rdEx),
        .memReadEx     (memReadEx),
        .branchTakenEx (branchTakenEx),
        .rdMem         (rdMem),
        .regWriteMem   (regWriteMem),
        .memReqMem     (memReqMem),
        .memBusy       (memBusy),
        .rdWb          (rdWb),
        .regWriteWb    (regWriteWb),
        .pcStall       (pcStall),
        .ifIdStall     (ifIdStall),
        .ifIdFlush     (ifIdFlush),
        .idExStall     (idExStall),
        .idExFlush     (idExFlush),
        .exMemStall    (exMemStall),
        .memWbFlush    (memWbFlush),
        .forwardA      (forwardA),
        .forwardB      (forwardB),
        .memTimeout    (memTimeout),
        .stallCycles   (stallCycles),
        .flushCount    (flushCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and land 1 time unit after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // {pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall, memWbFlush}
    function automatic logic [31:0] ctl();
        return {25'd0, pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall, memWbFlush};
    endfunction

    task automatic clear_inputs();
        rs1Id = 5'd0; rs2Id = 5'd0; useRs1Id = 1'b0; useRs2Id = 1'b0;
        rs1Ex = 5'd0; rs2Ex = 5'd0; rdEx = 5'd0; memReadEx = 1'b0;
        branchTakenEx = 1'b0; rdMem = 5'd0; regWriteMem = 1'b0;
        memReqMem = 1'b0; memBusy = 1'b0; rdWb = 5'd0; regWriteWb = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        check("reset_ctl", ctl(), 32'h0);
        check("reset_stall_cnt", stallCycles, 32'd0);
        check("reset_flush_cnt", 32'(flushCount), 32'd0);
        check("reset_timeout", 32'(memTimeout), 32'd0);
        check("reset_state", 32'(dut.state_r), 32'(RUN));
        reset = 1'b0;

        // Forwarding priority
        rs1Ex = 5'd5; rs2Ex = 5'd5; rdMem = 5'd5; regWriteMem = 1'b1; rdWb = 5'd5; regWriteWb = 1'b1;
        #1;
        check("fwdA_mem", 32'(forwardA), 32'(2'b10));
        check("fwdB_mem", 32'(forwardB), 32'(2'b10));
        regWriteMem = 1'b0;
        #1;
        check("fwdA_wb", 32'(forwardA), 32'(2'b01));
        rdMem = 5'd0; rdWb = 5'd0; regWriteMem = 1'b1;
        #1;
        check("fwdA_x0", 32'(forwardA), 32'(2'b00));
        rs2Ex = 5'd3; rdWb = 5'd3; rdMem = 5'd9;
        #1;
        check("fwdB_wb", 32'(forwardB), 32'(2'b01));
        check("fwdA_none", 32'(forwardA), 32'(2'b00));
        check("fwd_no_ctl", ctl(), 32'h0);
        clear_inputs();

        // Load-use: one-cycle stall
        tick();
        memReadEx = 1'b1; rdEx = 5'd7; rs2Id = 5'd7; useRs2Id = 1'b1;
        #1;
        check("lu_ctl", ctl(), 32'b1100100);
        tick();
        check("lu_stall_cnt", stallCycles, 32'd1);
        memReadEx = 1'b0; rdEx = 5'd0;
        #1;
        check("lu_released", ctl(), 32'h0);

        // x0 load destination never stalls
        memReadEx = 1'b1; rdEx = 5'd0; rs1Id = 5'd0; useRs1Id = 1'b1;
        #1;
        check("lu_x0", ctl(), 32'h0);
        clear_inputs();

        // Branch and load-use together: flush wins
        tick();
        branchTakenEx = 1'b1; memReadEx = 1'b1; rdEx = 5'd7; rs2Id = 5'd7; useRs2Id = 1'b1;
        #1;
        check("br_lu_ctl", ctl(), 32'b0010100);
        tick();
        check("br_flush_cnt", 32'(flushCount), 32'd1);
        check("br_stall_cnt", stallCycles, 32'd1);
        clear_inputs();

        // Memory wait with a branch held in EX
        branchTakenEx = 1'b1; memReqMem = 1'b1; memBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_ctl", ctl(), 32'b1101011);
            tick();
        end
        check("mw_state", 32'(dut.state_r), 32'(MEM_WAIT));
        memReqMem = 1'b0; memBusy = 1'b0;
        #1;
        check("mw_branch_flush", ctl(), 32'b0010100);
        tick();
        check("mw_state_run", 32'(dut.state_r), 32'(RUN));
        check("mw_flush_cnt", 32'(flushCount), 32'd2);
        check("mw_stall_cnt", stallCycles, 32'd4);
        check("mw_no_timeout", 32'(memTimeout), 32'd0);

        // flushCount saturates at all-ones
        tick();
        tick();
        check("flush_sat", 32'(flushCount), 32'd3);
        branchTakenEx = 1'b0;

        // Timeout: 6 cycles of memBusy with limit 4
        memReqMem = 1'b1; memBusy = 1'b1;
        tick();
        tick();
        tick();
        check("to_early", 32'(memTimeout), 32'd0);
        tick();
        tick();
        tick();
        check("to_raised", 32'(memTimeout), 32'd1);
        memReqMem = 1'b0; memBusy = 1'b0;
        tick();
        check("to_sticky", 32'(memTimeout), 32'd1);
        check("to_state_run", 32'(dut.state_r), 32'(RUN));
        check("to_stall_cnt", stallCycles, 32'd10);

        // Reset in the middle of a memory stall
        memReqMem = 1'b1; memBusy = 1'b1;
        tick();
        check("rs_pre_stall", ctl(), 32'b1101011);
        reset = 1'b1;
        #1;
        check("rs_ctl_gated", ctl(), 32'h0);
        tick();
        check("rs_ctl", ctl(), 32'h0);
        check("rs_stall_cnt", stallCycles, 32'd0);
        check("rs_flush_cnt", 32'(flushCount), 32'd0);
        check("rs_timeout", 32'(memTimeout), 32'd0);
        check("rs_state", 32'(dut.state_r), 32'(RUN));
        reset = 1'b0;
        clear_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
